// File: rtl/receiver.sv
// 8N1 serial receiver: synchronizes IN, samples each bit at mid-bit and holds the
// received byte in a one-entry register with a valid/taken handshake.
`timescale 1ns/1ps
module receiver #(
    parameter int unsigned T = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN,
    output logic [7:0] data,
    output logic       valid,
    input  logic       taken,
    output logic       ferr,
    output logic       ovf
);

    localparam int unsigned CW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CW-1:0] CntHalf = CW'(T / 2 - 1);
    localparam logic [CW-1:0] CntLast = CW'(T - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q;
    logic            meta_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bitidx_q;
    logic [7:0]      shift_q;
    logic            deliver_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            meta_q    <= 1'b1;
            rx_s      <= 1'b1;
            cnt_q     <= '0;
            bitidx_q  <= 3'd0;
            shift_q   <= 8'h00;
            deliver_q <= 1'b0;
            data      <= 8'h00;
            valid     <= 1'b0;
            ferr      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            meta_q    <= IN;
            rx_s      <= meta_q;
            ferr      <= 1'b0;
            deliver_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        // A start bit that is high again at mid-bit was only a glitch.
                        cnt_q    <= '0;
                        bitidx_q <= 3'd0;
                        state_q  <= rx_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q             <= '0;
                        shift_q[bitidx_q] <= rx_s;
                        if (bitidx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bitidx_q <= bitidx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            deliver_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            ferr    <= 1'b1;
                            state_q <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StBreak: begin
                    // Hold off until the line idles so a held-low line yields one error only.
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (deliver_q) begin
                if (!valid || taken) begin
                    data  <= shift_q;
                    valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (valid && taken) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: expected bytes are queued as frames are sent
// and compared when valid is raised.
`timescale 1ns/1ps
module tb_receiver;

    localparam int unsigned T = 16;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b0;
    logic       IN    = 1'b1;
    logic       taken = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovf;

    receiver #(.T(T)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IN    (IN),
        .data  (data),
        .valid (valid),
        .taken (taken),
        .ferr  (ferr),
        .ovf   (ovf)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ferr_hi = 0;
    int vld_hi = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    logic [7:0] exp_q[$];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ferr === 1'b1) ferr_hi <= ferr_hi + 1;
        if (valid === 1'b1) vld_hi <= vld_hi + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; leaves IN at the stop-bit value.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        IN = 1'b0;
        start_cyc = cyc;
        repeat (T) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            IN = b[i];
            repeat (T) @(negedge CLK);
        end
        IN = stop_bit;
        repeat (T) @(negedge CLK);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 * T; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                valid_cyc = cyc;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic pop_check(input string name, input bit take);
        bit ok;
        logic [7:0] exp;
        wait_valid(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: valid never rose, got valid=%b want 1", name, valid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected byte data=%h, nothing expected", name, data);
            return;
        end
        exp = exp_q.pop_front();
        if (data !== exp) begin
            fails++;
            $display("FAIL %s: data=%h want %h", name, data, exp);
        end
        if (take) begin
            taken = 1'b1;
            @(negedge CLK);
            taken = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        tests++; if (valid !== 1'b0)   begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
        tests++; if (data !== 8'h00)   begin fails++; $display("FAIL rst_data: got %h want 00", data); end
        tests++; if (ferr !== 1'b0)    begin fails++; $display("FAIL rst_ferr: got %b want 0", ferr); end
        tests++; if (ovf !== 1'b0)     begin fails++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        RST = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_single;
        int f0;
        int lat;
        f0 = ferr_hi;
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            pop_check("single_a5", 1'b1);
        join
        lat = valid_cyc - start_cyc;
        tests++;
        if (lat < 9 * T + T / 2 + 1 || lat > 9 * T + T / 2 + 5) begin
            fails++;
            $display("FAIL single_latency: got %0d want %0d +-2", lat, 9 * T + T / 2 + 3);
        end
        tests++; if (ferr_hi != f0) begin fails++; $display("FAIL single_ferr: pulses %0d want 0", ferr_hi - f0); end
        tests++; if (ovf !== 1'b0)  begin fails++; $display("FAIL single_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back;
        int f0;
        f0 = ferr_hi;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
                send_byte(8'h3C, 1'b1);
            end
            begin
                pop_check("b2b_00", 1'b1);
                pop_check("b2b_ff", 1'b1);
                pop_check("b2b_3c", 1'b1);
            end
        join
        repeat (4) @(negedge CLK);
        tests++; if (ferr_hi != f0)     begin fails++; $display("FAIL b2b_ferr: pulses %0d want 0", ferr_hi - f0); end
        tests++; if (ovf !== 1'b0)      begin fails++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_queue: left %0d want 0", exp_q.size()); end
    endtask

    task automatic test_framing;
        int f0;
        int v0;
        f0 = ferr_hi;
        v0 = vld_hi;
        send_byte(8'h55, 1'b0);
        repeat (3 * T) @(negedge CLK);
        IN = 1'b1;
        repeat (2 * T) @(negedge CLK);
        tests++; if (ferr_hi - f0 != 1) begin fails++; $display("FAIL ferr_pulse: high cycles %0d want 1", ferr_hi - f0); end
        tests++; if (vld_hi != v0)      begin fails++; $display("FAIL ferr_valid: valid cycles %0d want 0", vld_hi - v0); end
        exp_q.push_back(8'h12);
        fork
            send_byte(8'h12, 1'b1);
            pop_check("after_break_12", 1'b1);
        join
    endtask

    task automatic test_glitch;
        int f0;
        int v0;
        f0 = ferr_hi;
        v0 = vld_hi;
        IN = 1'b0;
        repeat (3) @(negedge CLK);
        IN = 1'b1;
        repeat (12 * T) @(negedge CLK);
        tests++; if (vld_hi != v0)  begin fails++; $display("FAIL glitch_valid: valid cycles %0d want 0", vld_hi - v0); end
        tests++; if (ferr_hi != f0) begin fails++; $display("FAIL glitch_ferr: pulses %0d want 0", ferr_hi - f0); end
        tests++; if (ovf !== 1'b0)  begin fails++; $display("FAIL glitch_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overrun;
        exp_q.push_back(8'h11);
        fork
            send_byte(8'h11, 1'b1);
            pop_check("ovr_first_11", 1'b0);
        join
        send_byte(8'h22, 1'b1);
        repeat (T) @(negedge CLK);
        tests++; if (data !== 8'h11) begin fails++; $display("FAIL ovr_data: got %h want 11", data); end
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b want 1", valid); end
        tests++; if (ovf !== 1'b1)   begin fails++; $display("FAIL ovr_flag: got %b want 1", ovf); end
        taken = 1'b1;
        @(negedge CLK);
        taken = 1'b0;
        repeat (2) @(negedge CLK);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL ovr_consume: valid %b want 0", valid); end
        tests++; if (ovf !== 1'b1)   begin fails++; $display("FAIL ovr_sticky: got %b want 1", ovf); end
        tests++; if (data !== 8'h11) begin fails++; $display("FAIL ovr_hold: got %h want 11", data); end
    endtask

    task automatic test_reset_midframe;
        int f0;
        int v0;
        logic [7:0] b;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst2_ovf: got %b want 0", ovf); end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        f0 = ferr_hi;
        v0 = vld_hi;
        b = 8'h99;
        IN = 1'b0;
        repeat (T) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            IN = b[i];
            repeat (T) @(negedge CLK);
        end
        IN = b[4];
        repeat (T / 2) @(negedge CLK);
        RST = 1'b0;
        IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (12 * T) @(negedge CLK);
        tests++; if (vld_hi != v0)  begin fails++; $display("FAIL abort_valid: valid cycles %0d want 0", vld_hi - v0); end
        tests++; if (ferr_hi != f0) begin fails++; $display("FAIL abort_ferr: pulses %0d want 0", ferr_hi - f0); end
        tests++; if (ovf !== 1'b0)  begin fails++; $display("FAIL abort_ovf: got %b want 0", ovf); end
        exp_q.push_back(8'h42);
        fork
            send_byte(8'h42, 1'b1);
            pop_check("after_abort_42", 1'b1);
        join
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: left %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- UART-style serial receiver for the 8N1 frame used on the board link.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line high.
- Oversamples the asynchronous IN line at mid-bit, reassembles the byte, and holds it in a one-entry output register with a valid/taken handshake.
- Sits between the board serial pin and the core's input path; it is the counterpart to the serial transmit path.

Parameters:
- T, 868, clock cycles per serial bit (100 MHz / 115200 baud). Must be ≥ 8; simulation uses T=16.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset. Asserting it low immediately resets all state; it releases synchronously to CLK.
- IN  input  1  serial line, asynchronous to CLK, idle high.
- data  output  8  last received byte; stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- taken  input  1  consumer accepts data this cycle; ignored when valid=0.
- ferr  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
- ovf  output  1  sticky overrun flag; cleared only by reset.

Behaviour:
- Reset values: data=0, valid=0, ferr=0, ovf=0, state=IDLE, counters=0, both synchronizer flops=1.
- Input sync: IN passes through a 2-flop synchronizer to produce rx_s. Only rx_s is used internally.
- Counters: cnt counts bit-time cycles, sized for values 0..T-1. bitidx is 3 bits.
- State machine:
  - IDLE: rx_s==0 -> START, cnt<=0.
  - START: increment cnt. At cnt==T/2-1 (integer division), sample rx_s:
    - 0 -> DATA, cnt<=0, bitidx<=0.
    - 1 -> IDLE. This is a glitch; nothing is reported.
  - DATA: increment cnt. At cnt==T-1, shift[bitidx]<=rx_s and cnt<=0. After bitidx==7 is sampled -> STOP; otherwise bitidx+1.
  - STOP: increment cnt. At cnt==T-1, sample rx_s:
    - 1 -> deliver the byte, then go to IDLE.
    - 0 -> ferr=1 for exactly one cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. This keeps a held-low line (break condition) from producing repeated frames.
- Sampling point: every sample is taken at mid-bit. Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
- Delivery, in the cycle after a good stop sample:
  - If valid==0, or valid==1 with taken==1 in the same cycle: data<=shift, valid<=1. Simultaneous consume and deliver leaves valid high with the new byte.
  - If valid==1 and taken==0: the new byte is dropped, data is unchanged, ovf<=1.
- Consume: taken==1 with valid==1 and no delivery that cycle -> valid<=0 on the next edge. data keeps its value.
- Latency: valid rises nominally 9*T + T/2 + 3 cycles after the falling edge of the start bit on IN. The bench accepts ±2 cycles.
- Reset asserted mid-frame aborts the frame: state returns to IDLE and no valid, ferr or ovf is raised. After release, a line already low is treated as a new start edge.
- Throughput: sustains continuous back-to-back frames with zero idle bits between them.

Test Plan:
- T=16, send 0xA5 with a correct frame -> valid=1 and data=0xA5 at 9*16+8+3 cycles ±2 after the start edge; ferr=0 and ovf=0 throughout.
- Send 0x00, 0xFF, 0x3C back-to-back with no idle bits, pulsing taken one cycle after each valid -> three bytes are received in order with no ferr and no ovf.
- Send a 0x55 frame with the stop bit driven 0, and hold the line low for 3T afterwards -> ferr pulses once (one cycle), valid stays 0, and no further frame is decoded until the line returns high. Then send 0x12 -> valid with data=0x12.
- Pulse IN low for 3 cycles (shorter than T/2) -> no state change; valid, ferr and ovf all stay 0.
- Send 0x11 without taken, then send 0x22 -> data stays 0x11 and ovf=1. Assert taken -> valid=0, ovf remains 1 until reset.
- Assert RST low in the middle of the data bits of a 0x99 frame, release, then send 0x42 -> no output from the aborted frame; valid with data=0x42 follows.
